// File: rtl/rps_pkg.sv
// Shared codes and scoring rule for the rock-paper-scissors match controller.
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10
  } choice_e;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    FPGA_WIN = 2'b01,
    USER_WIN = 2'b10,
    DRAW     = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PICK = 2'd1,
    EVAL      = 2'd2,
    OVER      = 2'd3
  } state_e;

  // Scores one round from the user's point of view; the caller handles timeouts.
  function automatic logic [1:0] rps_judge(input logic [1:0] user, input logic [1:0] fpga);
    logic [1:0] res;
    res = FPGA_WIN;
    if (user == fpga) begin
      res = DRAW;
    end else if ((user == ROCK     && fpga == SCISSORS) ||
                 (user == PAPER    && fpga == ROCK)     ||
                 (user == SCISSORS && fpga == PAPER)) begin
      res = USER_WIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/rps_lfsr.sv
// Free-running Galois LFSR used as the FPGA move source.
module rps_lfsr #(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              clear_n,
  output logic [LFSR_W-1:0] lfsr
);

  // Right-shifting Galois step every clock; a stuck-at-zero state is recovered by reloading the seed.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == '0) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match controller: button conditioning,
// FPGA move generation, per-round timeout and match scoring.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int                WIN_TARGET  = 3,
  parameter int                SCORE_W     = 3,
  parameter int                RND_W       = 4,
  parameter int                LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5,
  parameter int                TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic               s1,
  input  logic               s2,
  input  logic               s3,
  output logic [1:0]         fpga_choice,
  output logic [1:0]         user_choice,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] fpga_score,
  output logic [RND_W-1:0]   round_cnt,
  output logic               round_done,
  output logic               timed_out,
  output logic               busy,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT_PICK;
  localparam logic [1:0] ST_EVAL = EVAL;
  localparam logic [1:0] ST_OVER = OVER;

  logic [1:0]         state;
  logic [TO_W-1:0]    tcnt;
  logic               to_flag;
  logic [LFSR_W-1:0]  lfsr;
  logic [1:0]         lfsr_mod3;
  logic [3:0]         btn_raw;
  logic [3:0]         pulse;
  logic               start_p;
  logic               pick_any;
  logic [1:0]         pick_code;
  logic [1:0]         round_res;
  logic               user_win;
  logic               fpga_win;
  logic [SCORE_W-1:0] user_next;
  logic [SCORE_W-1:0] fpga_next;
  logic [RND_W-1:0]   round_next;
  logic               target_hit;

  rps_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .clear_n (clear_n),
    .lfsr    (lfsr)
  );

  assign btn_raw   = {s3, s2, s1, start};
  assign lfsr_mod3 = 2'(lfsr % LFSR_W'(3));
  assign start_p   = pulse[0];

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic sync_a;
    logic sync_b;
    logic sync_d;
    logic edge_q;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
        sync_d <= 1'b0;
        edge_q <= 1'b0;
      end else begin
        sync_a <= btn_raw[i];
        sync_b <= sync_a;
        sync_d <= sync_b;
        edge_q <= sync_b & ~sync_d;
      end
    end

    assign pulse[i] = edge_q;
  end

  // Priority-encode the user pick (rock over paper over scissors) and work out the round outcome.
  always_comb begin
    pick_any  = |pulse[3:1];
    pick_code = SCISSORS;
    if (pulse[1]) begin
      pick_code = ROCK;
    end else if (pulse[2]) begin
      pick_code = PAPER;
    end
    round_res  = to_flag ? FPGA_WIN : rps_judge(user_choice, fpga_choice);
    user_win   = (round_res == USER_WIN) && (user_score != TARGET);
    fpga_win   = (round_res == FPGA_WIN) && (fpga_score != TARGET);
    user_next  = user_score + {{(SCORE_W-1){1'b0}}, user_win};
    fpga_next  = fpga_score + {{(SCORE_W-1){1'b0}}, fpga_win};
    round_next = (round_cnt == '1) ? round_cnt : round_cnt + RND_W'(1);
    target_hit = (user_win && (user_next == TARGET)) || (fpga_win && (fpga_next == TARGET));
  end

  // Match state machine; all visible outputs are registered here.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state        <= ST_IDLE;
      tcnt         <= '0;
      to_flag      <= 1'b0;
      fpga_choice  <= 2'b00;
      user_choice  <= 2'b00;
      result       <= NONE;
      user_score   <= '0;
      fpga_score   <= '0;
      round_cnt    <= '0;
      round_done   <= 1'b0;
      timed_out    <= 1'b0;
      match_winner <= 2'b00;
    end else begin
      round_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_p) begin
            fpga_choice <= lfsr_mod3;
            tcnt        <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pick_any) begin
            user_choice <= pick_code;
            to_flag     <= 1'b0;
            state       <= ST_EVAL;
          end else if (tcnt == TO_LAST) begin
            to_flag <= 1'b1;
            state   <= ST_EVAL;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        ST_EVAL: begin
          result     <= round_res;
          timed_out  <= to_flag;
          round_done <= 1'b1;
          user_score <= user_next;
          fpga_score <= fpga_next;
          round_cnt  <= round_next;
          if (target_hit) begin
            match_winner <= round_res;
            state        <= ST_OVER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_OVER: begin
          if (start_p) begin
            user_score   <= '0;
            fpga_score   <= '0;
            round_cnt    <= '0;
            match_winner <= 2'b00;
            result       <= NONE;
            fpga_choice  <= lfsr_mod3;
            tcnt         <= '0;
            state        <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state == ST_WAIT) || (state == ST_EVAL);
  assign match_over = (state == ST_OVER);

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: directed corner cases, a vector
// table of round outcomes and randomised rounds against a reference model.
module tb_rps_match_ctrl;

  localparam int T  = 20;
  localparam int WT = 3;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       start = 1'b0;
  logic       s1 = 1'b0;
  logic       s2 = 1'b0;
  logic       s3 = 1'b0;
  logic [1:0] fpga_choice;
  logic [1:0] user_choice;
  logic [1:0] result;
  logic [2:0] user_score;
  logic [2:0] fpga_score;
  logic [3:0] round_cnt;
  logic       round_done;
  logic       timed_out;
  logic       busy;
  logic       match_over;
  logic [1:0] match_winner;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr;
  int m_f, m_u, m_res, m_user, m_fpga, m_round, m_timed, m_over, m_winner;

  typedef struct {
    int offset;
    int exp_result;
    int d_user;
    int d_fpga;
  } vec_t;
  vec_t tbl[6];

  rps_match_ctrl #(
    .WIN_TARGET  (WT),
    .SCORE_W     (3),
    .RND_W       (4),
    .LFSR_W      (8),
    .LFSR_TAPS   (8'hB8),
    .LFSR_SEED   (8'hA5),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .start        (start),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .fpga_choice  (fpga_choice),
    .user_choice  (user_choice),
    .result       (result),
    .user_score   (user_score),
    .fpga_score   (fpga_score),
    .round_cnt    (round_cnt),
    .round_done   (round_done),
    .timed_out    (timed_out),
    .busy         (busy),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  // One step of the x^8+x^6+x^5+x^4+1 sequence written as integer arithmetic.
  function automatic int lfsr_step(input int v);
    if (v == 0) return 'hA5;
    return (v / 2) ^ (((v % 2) == 1) ? 'hB8 : 0);
  endfunction

  // Reference LFSR running in lockstep with the board clock.
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= 8'(lfsr_step(int'(m_lfsr)));
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int busy_e, input int done_e);
    checkOutput({tag, " fpga_choice"},  int'(fpga_choice),  m_f);
    checkOutput({tag, " user_choice"},  int'(user_choice),  m_u);
    checkOutput({tag, " result"},       int'(result),       m_res);
    checkOutput({tag, " user_score"},   int'(user_score),   m_user);
    checkOutput({tag, " fpga_score"},   int'(fpga_score),   m_fpga);
    checkOutput({tag, " round_cnt"},    int'(round_cnt),    m_round);
    checkOutput({tag, " timed_out"},    int'(timed_out),    m_timed);
    checkOutput({tag, " match_over"},   int'(match_over),   m_over);
    checkOutput({tag, " match_winner"}, int'(match_winner), m_winner);
    checkOutput({tag, " busy"},         int'(busy),         busy_e);
    checkOutput({tag, " round_done"},   int'(round_done),   done_e);
  endtask

  task automatic modelReset();
    m_f = 0; m_u = 0; m_res = 0; m_user = 0; m_fpga = 0;
    m_round = 0; m_timed = 0; m_over = 0; m_winner = 0;
  endtask

  // Called on a falling edge; holds the mask for 'hold' cycles, returns on a falling edge.
  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    {s3, s2, s1, start} = mask;
    repeat (hold) @(negedge clk);
    {s3, s2, s1, start} = 4'b0000;
  endtask

  // Winner gets a point, draws score nothing, match ends on reaching the target.
  task automatic scoreModel(input int u, input int timeout);
    int res;
    if (timeout != 0) begin
      res = 1;
    end else begin
      case ((u - m_f + 3) % 3)
        0:       res = 3;
        1:       res = 2;
        default: res = 1;
      endcase
      m_u = u;
    end
    if (res == 2 && m_user < WT) m_user++;
    if (res == 1 && m_fpga < WT) m_fpga++;
    if (m_round < 15) m_round++;
    m_res = res;
    m_timed = timeout;
    if (m_user == WT) begin
      m_over = 1; m_winner = 2;
    end else if (m_fpga == WT) begin
      m_over = 1; m_winner = 1;
    end
  endtask

  task automatic startRound(input string tag);
    int pred;
    applyStimulus(4'b0001, 1);
    repeat (2) @(negedge clk);
    pred = int'(m_lfsr) % 3;
    @(negedge clk);
    if (m_over != 0) begin
      m_user = 0; m_fpga = 0; m_round = 0; m_winner = 0; m_res = 0; m_over = 0;
    end
    m_f = pred;
    checkAll({tag, " start"}, 1, 0);
  endtask

  task automatic pickRound(input string tag, input logic [3:0] mask);
    int u;
    u = mask[1] ? 0 : (mask[2] ? 1 : 2);
    applyStimulus(mask, 1);
    repeat (3) @(negedge clk);
    checkOutput({tag, " eval busy"}, int'(busy), 1);
    checkOutput({tag, " eval done early"}, int'(round_done), 0);
    @(negedge clk);
    scoreModel(u, 0);
    checkAll({tag, " scored"}, 0, 1);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, int'(round_done), 0);
  endtask

  task automatic timeoutRound(input string tag);
    int k;
    k = 1;
    while (k <= 100) begin
      @(negedge clk);
      if (round_done) break;
      k++;
    end
    checkOutput({tag, " timeout latency"}, k, T + 1);
    scoreModel(m_u, 1);
    checkAll({tag, " timeout"}, 0, 1);
  endtask

  function automatic logic [3:0] pickFor(input int offset);
    int u;
    u = (m_f + offset) % 3;
    return 4'(2 << u);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int guard;
    int pu;
    int pf;
    tbl[0] = '{0, 3, 0, 0};
    tbl[1] = '{0, 3, 0, 0};
    tbl[2] = '{0, 3, 0, 0};
    tbl[3] = '{0, 3, 0, 0};
    tbl[4] = '{1, 2, 1, 0};
    tbl[5] = '{2, 1, 0, 1};

    // Reset with s1 held: nothing may happen when it is released.
    modelReset();
    s1 = 1'b1;
    #1 clear_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset", 0, 0);
    clear_n = 1'b1;
    repeat (6) @(negedge clk);
    checkAll("held s1", 0, 0);
    s1 = 1'b0;
    repeat (3) @(negedge clk);

    // Time the start press so the FPGA draws scissors, then beat it with rock.
    guard = 0;
    while (((lfsr_step(lfsr_step(lfsr_step(int'(m_lfsr))))) % 3) != 2 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scissors search", guard < 60 ? 1 : 0, 1);
    startRound("r1");
    checkOutput("r1 fpga scissors", int'(fpga_choice), 2);
    pickRound("r1", 4'b0010);
    checkOutput("r1 user_score", int'(user_score), 1);

    // Simultaneous rock and paper: rock wins the priority.
    startRound("dual");
    pickRound("dual", 4'b0110);
    checkOutput("dual user_choice", int'(user_choice), 0);

    // No pick at all: forced FPGA win.
    startRound("to");
    timeoutRound("to");
    checkOutput("to result", int'(result), 1);

    // User wins until the match closes.
    guard = 0;
    while (m_over == 0 && guard < 10) begin
      startRound("win");
      pickRound("win", pickFor(1));
      guard++;
    end
    checkOutput("match_over", int'(match_over), 1);
    checkOutput("match_winner", int'(match_winner), 2);
    checkOutput("final user_score", int'(user_score), 3);

    // Choices are dead while the match is over.
    applyStimulus(4'b0100, 1);
    repeat (8) @(negedge clk);
    checkAll("over s2", 0, 0);

    startRound("restart");
    checkOutput("restart round_cnt", int'(round_cnt), 0);

    // Start again mid-round changes nothing.
    applyStimulus(4'b0001, 1);
    repeat (6) @(negedge clk);
    checkAll("start ignored", 1, 0);

    // Outcome table, first entry uses the round already open.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) startRound("vec");
      pu = m_user;
      pf = m_fpga;
      pickRound("vec", pickFor(tbl[i].offset));
      checkOutput("vec result", int'(result), tbl[i].exp_result);
      checkOutput("vec user delta", int'(user_score) - pu, tbl[i].d_user);
      checkOutput("vec fpga delta", int'(fpga_score) - pf, tbl[i].d_fpga);
      if (i == 3) begin
        checkOutput("draws round_cnt", int'(round_cnt), 4);
        checkOutput("draws scores", int'(user_score) + int'(fpga_score), 0);
      end
    end

    // Push the round counter into saturation with draws.
    for (int i = 0; i < 10; i++) begin
      startRound("sat");
      pickRound("sat", pickFor(0));
    end
    checkOutput("round saturate", int'(round_cnt), 15);

    // Random rounds against the model.
    for (int i = 0; i < 24; i++) begin
      startRound("rnd");
      if ($urandom_range(0, 7) == 0) begin
        timeoutRound("rnd");
      end else begin
        pickRound("rnd", 4'($urandom_range(1, 7) << 1));
      end
    end

    // Asynchronous reset while waiting for a pick after a scored round.
    startRound("pre");
    pickRound("pre", pickFor(1));
    startRound("pre2");
    #2 clear_n = 1'b0;
    #1 modelReset();
    checkAll("async reset", 0, 0);
    @(negedge clk);
    clear_n = 1'b1;
    startRound("post");
    pickRound("post", pickFor(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
# rps_match_ctrl

Parametrised best-of-N rock-paper-scissors match controller for the FPGA game board. It synchronises and edge-detects the start and choice buttons, draws the FPGA move from an internal LFSR, and scores each round. It enforces a per-round response timeout and declares a match winner when either side reaches the target score. It sits between the board buttons and the LED/7-segment display logic, which consumes its registered outputs.

## Interface

- WIN_TARGET, 3: round wins needed to take the match (1..2^SCORE_W-1)
- SCORE_W, 3: width of each score counter
- RND_W, 4: width of the round counter (saturating)
- LFSR_W, 8: LFSR width
- LFSR_TAPS, 8'hB8: Galois feedback mask (x^8+x^6+x^5+x^4+1)
- LFSR_SEED, 8'hA5: reset value, non-zero
- TIMEOUT_CYC, 50_000_000: clocks allowed for a user pick
- clk  in  1  system clock
- clear_n  in  1  reset, asynchronous assert, active-low
- start  in  1  start/next-round button, asynchronous
- s1, s2, s3  in  1 each  rock / paper / scissors buttons, asynchronous
- fpga_choice  out  2  FPGA move (00 rock, 01 paper, 10 scissors)
- user_choice  out  2  user move, same encoding
- result  out  2  00 none, 11 draw, 01 FPGA wins, 10 user wins
- user_score, fpga_score  out  SCORE_W each  round wins this match
- round_cnt  out  RND_W  rounds played this match
- round_done  out  1  one-cycle pulse per scored round
- timed_out  out  1  last round ended by timeout
- busy  out  1  high in WAIT_PICK and EVAL
- match_over  out  1  high in OVER
- match_winner  out  2  01 FPGA, 10 user, 00 while no winner

## Operation

- Each button passes through a 2-flop synchroniser and a rising-edge detector, giving a one-cycle internal pulse.
- LFSR advances every clock. A zero state reloads LFSR_SEED.
- States: IDLE, WAIT_PICK, EVAL, OVER.
- IDLE, start pulse: latch fpga_choice = lfsr % 3, clear the timeout counter, go to WAIT_PICK.
- WAIT_PICK, choice pulse: latch user_choice and go to EVAL. Simultaneous pulses use priority s1 > s2 > s3. A start pulse here is ignored.
- WAIT_PICK, timeout counter reaches TIMEOUT_CYC-1 with no pick: go to EVAL with a forced FPGA win, timed_out=1, user_choice unchanged.
- EVAL (one cycle) updates result, scores, round_cnt, timed_out and round_done:
  - Result: draw if the moves are equal; user wins on rock>scissors, paper>rock or scissors>paper; otherwise FPGA wins.
  - The winner's score increments. A draw changes neither score.
  - round_cnt increments and saturates at all-ones.
  - Next state is OVER if the winner's new score equals WIN_TARGET, otherwise IDLE.
- OVER: match_winner is set and buttons s1–s3 are ignored. A start pulse zeroes the scores, round_cnt and match_winner, sets result=00, latches a new fpga_choice and goes to WAIT_PICK.
- Scores never exceed WIN_TARGET and never wrap.

## Timing

- Pin-to-pulse latency is 3 clocks (two sync stages plus the edge register).
- The choice pulse in WAIT_PICK leads to EVAL on the next cycle. Outputs from EVAL update on the edge leaving EVAL, so result is visible 2 clocks after the internal pulse.
- round_done is high for exactly the one cycle after EVAL.
- match_over rises in the same cycle that round_done is high.
- Reset values:
  - State IDLE, lfsr LFSR_SEED.
  - All outputs zero.
  - Synchroniser and edge registers zero, so a button held through reset produces no pulse.
- Reset mid-round returns to IDLE asynchronously. No partial score survives.
- A button held high gives one pulse only. Releasing and re-pressing gives a new pulse.

## Structure

- Package rps_pkg:
  - Choice codes ROCK/PAPER/SCISSORS.
  - Result codes NONE/DRAW/FPGA_WIN/USER_WIN.
  - State enum.
  - Function rps_judge(user, fpga) returning a result code.
- Sub-module rps_lfsr, parametrised by LFSR_W, LFSR_TAPS and LFSR_SEED, with free-running output.
- Synchroniser and edge detector inline in a generate loop over the four buttons.

## Test plan

The bench models the LFSR (seed A5, taps B8) to predict fpga_choice.

- Reset held low with s1 high, then released: all outputs 0 and no pulse. Release s1, press start, then s1 with fpga_choice=10 → result=10, user_score=1, round_done one cycle.
- s1 and s2 rise on the same clock in WAIT_PICK → user_choice=00.
- No pick for TIMEOUT_CYC (set to 20) → result=01, timed_out=1, fpga_score+1.
- Drive 3 user wins with WIN_TARGET=3 → match_over=1, match_winner=10, user_score=3. Further s2 presses change nothing. Start → scores and round_cnt 0, busy=1.
- Four draws → scores stay 0 and round_cnt=4. Start pressed during WAIT_PICK → no state change.
- clear_n pulsed low while in WAIT_PICK after one scored round → immediate IDLE, all outputs 0, lfsr=A5.
